// File: rtl/mem_access.sv
// Memory-access / writeback stage: issues load/store transactions on a req/gnt/rvalid data bus
// and drives one register-file writeback port. Optional alignment check: MEM_MISALIGN_CHK_EN.
module mem_access #(
  parameter int unsigned RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_vld_i,
  output logic            in_ready_o,
  input  logic [RD_W-1:0] ex_rd_i,
  input  logic [31:0]     ex_x_rd_i,
  input  logic            ex_x_rd_vld_i,
  input  logic [31:0]     mem_addr_i,
  input  logic [3:0]      mem_rden_i,
  input  logic [3:0]      mem_wren_i,
  input  logic [31:0]     mem_wrdata_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [31:0]     dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [31:0]     dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [31:0]     dbus_rdata_i,
  output logic            wb_we_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [31:0]     wb_data_o,
  output logic            error_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e          state_q;
  logic            dbus_req_q;
  logic            dbus_we_q;
  logic [31:0]     dbus_addr_q;
  logic [3:0]      dbus_be_q;
  logic [31:0]     dbus_wdata_q;
  logic [RD_W-1:0] rd_q;
  logic            wb_we_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [31:0]     wb_data_q;
  logic            error_q;

  logic        has_rd;
  logic        has_wr;
  logic        is_ld;
  logic        is_st;
  logic        is_bad;
  logic        is_mem;
  logic [3:0]  acc_be;
  logic        misalign;
  logic [31:0] lane_mask;
  logic [31:0] load_data;
  logic        ld_rd_nz;
  logic        ex_rd_nz;

  assign has_rd = |mem_rden_i;
  assign has_wr = |mem_wren_i;
  assign is_ld  = has_rd & ~has_wr;
  assign is_st  = has_wr & ~has_rd;
  assign is_bad = has_rd & has_wr;
  assign is_mem = is_ld | is_st;
  assign acc_be = is_ld ? mem_rden_i : mem_wren_i;

`ifdef MEM_MISALIGN_CHK_EN
  assign misalign = ((acc_be == 4'b1111) && (mem_addr_i[1:0] != 2'b00)) ||
                    (((acc_be == 4'b0011) || (acc_be == 4'b1100)) && mem_addr_i[0]);
`else
  assign misalign = 1'b0;
`endif

  // Bytes not enabled by the latched byte-enables read back as zero.
  assign lane_mask = {{8{dbus_be_q[3]}}, {8{dbus_be_q[2]}}, {8{dbus_be_q[1]}}, {8{dbus_be_q[0]}}};
  assign load_data = dbus_rdata_i & lane_mask;
  assign ld_rd_nz  = (rd_q != '0);
  assign ex_rd_nz  = (ex_rd_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      dbus_req_q   <= 1'b0;
      dbus_we_q    <= 1'b0;
      dbus_addr_q  <= '0;
      dbus_be_q    <= '0;
      dbus_wdata_q <= '0;
      rd_q         <= '0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      error_q      <= 1'b0;
    end else begin
      wb_we_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ex_vld_i) begin
            if (is_bad || (is_mem && misalign)) begin
              error_q <= 1'b1;
            end else if (is_mem) begin
              state_q      <= StReq;
              dbus_req_q   <= 1'b1;
              dbus_we_q    <= is_st;
              dbus_addr_q  <= {mem_addr_i[31:2], 2'b00};
              dbus_be_q    <= acc_be;
              dbus_wdata_q <= mem_wrdata_i;
              rd_q         <= ex_rd_i;
            end else if (ex_x_rd_vld_i && ex_rd_nz) begin
              wb_we_q   <= 1'b1;
              wb_rd_q   <= ex_rd_i;
              wb_data_q <= ex_x_rd_i;
            end
          end
        end
        StReq: begin
          if (dbus_gnt_i) begin
            dbus_req_q <= 1'b0;
            if (dbus_we_q) begin
              state_q <= StIdle;
            end else if (dbus_rvalid_i) begin
              state_q   <= StIdle;
              wb_we_q   <= ld_rd_nz;
              wb_rd_q   <= rd_q;
              wb_data_q <= load_data;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (dbus_rvalid_i) begin
            state_q   <= StIdle;
            wb_we_q   <= ld_rd_nz;
            wb_rd_q   <= rd_q;
            wb_data_q <= load_data;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o   = (state_q == StIdle);
  assign dbus_req_o   = dbus_req_q;
  assign dbus_we_o    = dbus_we_q;
  assign dbus_addr_o  = dbus_addr_q;
  assign dbus_be_o    = dbus_be_q;
  assign dbus_wdata_o = dbus_wdata_q;
  assign wb_we_o      = wb_we_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; expected values are hand-computed per scenario.
module tb_mem_access;

  localparam int unsigned RD_W = 5;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            ex_vld_i;
  logic            in_ready_o;
  logic [RD_W-1:0] ex_rd_i;
  logic [31:0]     ex_x_rd_i;
  logic            ex_x_rd_vld_i;
  logic [31:0]     mem_addr_i;
  logic [3:0]      mem_rden_i;
  logic [3:0]      mem_wren_i;
  logic [31:0]     mem_wrdata_i;
  logic            dbus_req_o;
  logic            dbus_we_o;
  logic [31:0]     dbus_addr_o;
  logic [3:0]      dbus_be_o;
  logic [31:0]     dbus_wdata_o;
  logic            dbus_gnt_i;
  logic            dbus_rvalid_i;
  logic [31:0]     dbus_rdata_i;
  logic            wb_we_o;
  logic [RD_W-1:0] wb_rd_o;
  logic [31:0]     wb_data_o;
  logic            error_o;

  int checks = 0;
  int failures = 0;

  mem_access #(.RD_W(RD_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ex_vld_i      (ex_vld_i),
    .in_ready_o    (in_ready_o),
    .ex_rd_i       (ex_rd_i),
    .ex_x_rd_i     (ex_x_rd_i),
    .ex_x_rd_vld_i (ex_x_rd_vld_i),
    .mem_addr_i    (mem_addr_i),
    .mem_rden_i    (mem_rden_i),
    .mem_wren_i    (mem_wren_i),
    .mem_wrdata_i  (mem_wrdata_i),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .wb_we_o       (wb_we_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ex_vld_i      = 1'b0;
    ex_rd_i       = '0;
    ex_x_rd_i     = '0;
    ex_x_rd_vld_i = 1'b0;
    mem_addr_i    = '0;
    mem_rden_i    = '0;
    mem_wren_i    = '0;
    mem_wrdata_i  = '0;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = '0;
  endtask

  task automatic test_reset();
    logic [78:0] outs;
    rst_ni = 1'b0;
    idle_inputs();
    #12;
    outs = {dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, wb_we_o, wb_rd_o,
            wb_data_o[0], error_o};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", outs);
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready_o);
    end
    checks++;
    if (wb_data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_wb_data got=%h exp=0", wb_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    ex_vld_i = 1'b1; ex_rd_i = 5'd5; ex_x_rd_i = 32'h0000_1234; ex_x_rd_vld_i = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({wb_we_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd5, 32'h0000_1234}) begin
      failures++;
      $display("FAIL alu_wb got=%b/%0d/%h exp=1/5/00001234", wb_we_o, wb_rd_o, wb_data_o);
    end
    checks++;
    if (in_ready_o !== 1'b1 || dbus_req_o !== 1'b0 || error_o !== 1'b0) begin
      failures++;
      $display("FAIL alu_side got=rdy%b req%b err%b exp=rdy1 req0 err0", in_ready_o, dbus_req_o,
               error_o);
    end
    tick();
    checks++;
    if (wb_we_o !== 1'b0) begin
      failures++;
      $display("FAIL alu_pulse got=%b exp=0", wb_we_o);
    end
  endtask

  task automatic test_back_to_back();
    // rd=1 writes, rd=0 is suppressed, ex_x_rd_vld=0 is suppressed
    ex_vld_i = 1'b1; ex_rd_i = 5'd1; ex_x_rd_i = 32'h1111_0001; ex_x_rd_vld_i = 1'b1;
    tick();
    ex_rd_i = 5'd0; ex_x_rd_i = 32'h2222_0002;
    checks++;
    if ({wb_we_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd1, 32'h1111_0001}) begin
      failures++;
      $display("FAIL b2b_first got=%b/%0d/%h exp=1/1/11110001", wb_we_o, wb_rd_o, wb_data_o);
    end
    tick();
    ex_rd_i = 5'd9; ex_x_rd_vld_i = 1'b0;
    checks++;
    if (wb_we_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rd0 got=%b exp=0", wb_we_o);
    end
    tick();
    idle_inputs();
    checks++;
    if (wb_we_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_novld got=%b exp=0", wb_we_o);
    end
  endtask

  task automatic test_load_wait();
    ex_vld_i = 1'b1; ex_rd_i = 5'd7; mem_addr_i = 32'h100; mem_rden_i = 4'hF;
    tick();
    idle_inputs();
    // two cycles without grant: request held stable
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, in_ready_o} !==
          {1'b1, 1'b0, 32'h100, 4'hF, 1'b0}) begin
        failures++;
        $display("FAIL ld_req_hold%0d got=req%b we%b a%h be%h rdy%b exp=req1 we0 a100 beF rdy0",
                 i, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, in_ready_o);
      end
      tick();
    end
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dbus_req_o !== 1'b0 || in_ready_o !== 1'b0 || wb_we_o !== 1'b0) begin
        failures++;
        $display("FAIL ld_wait%0d got=req%b rdy%b we%b exp=req0 rdy0 we0", i, dbus_req_o,
                 in_ready_o, wb_we_o);
      end
      tick();
    end
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++;
    if ({wb_we_o, wb_rd_o, wb_data_o, in_ready_o} !== {1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1}) begin
      failures++;
      $display("FAIL ld_wb got=%b/%0d/%h rdy%b exp=1/7/deadbeef rdy1", wb_we_o, wb_rd_o,
               wb_data_o, in_ready_o);
    end
    tick();
  endtask

  task automatic test_store();
    ex_vld_i = 1'b1; ex_rd_i = 5'd3; ex_x_rd_vld_i = 1'b1; ex_x_rd_i = 32'h77;
    mem_addr_i = 32'h104; mem_wren_i = 4'hF; mem_wrdata_i = 32'hA5A5_A5A5;
    tick();
    idle_inputs();
    checks++;
    if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, in_ready_o} !==
        {1'b1, 1'b1, 32'h104, 4'hF, 32'hA5A5_A5A5, 1'b0}) begin
      failures++;
      $display("FAIL st_req got=req%b we%b a%h be%h d%h rdy%b exp=req1 we1 a104 beF a5a5a5a5 rdy0",
               dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, in_ready_o);
    end
    checks++;
    if (wb_we_o !== 1'b0) begin
      failures++;
      $display("FAIL st_no_wb1 got=%b exp=0", wb_we_o);
    end
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    checks++;
    if (dbus_req_o !== 1'b0 || in_ready_o !== 1'b1 || wb_we_o !== 1'b0) begin
      failures++;
      $display("FAIL st_done got=req%b rdy%b we%b exp=req0 rdy1 we0", dbus_req_o, in_ready_o,
               wb_we_o);
    end
    tick();
  endtask

  task automatic test_load_rd0();
    ex_vld_i = 1'b1; ex_rd_i = 5'd0; mem_addr_i = 32'h200; mem_rden_i = 4'hF;
    tick();
    idle_inputs();
    checks++;
    if (dbus_req_o !== 1'b1) begin
      failures++;
      $display("FAIL ld0_req got=%b exp=1", dbus_req_o);
    end
    dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1122_3344;
    tick();
    idle_inputs();
    checks++;
    if (wb_we_o !== 1'b0 || in_ready_o !== 1'b1 || dbus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL ld0_done got=we%b rdy%b req%b exp=we0 rdy1 req0", wb_we_o, in_ready_o,
               dbus_req_o);
    end
  endtask

  task automatic test_byte_load();
    // single byte lane 2 at an unaligned byte address
    ex_vld_i = 1'b1; ex_rd_i = 5'd9; mem_addr_i = 32'h12; mem_rden_i = 4'b0100;
    tick();
    idle_inputs();
    checks++;
    if (dbus_addr_o !== 32'h10 || dbus_be_o !== 4'b0100) begin
      failures++;
      $display("FAIL bl_req got=a%h be%b exp=a10 be0100", dbus_addr_o, dbus_be_o);
    end
    dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hAABB_CCDD;
    tick();
    idle_inputs();
    checks++;
    if ({wb_we_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd9, 32'h00BB_0000}) begin
      failures++;
      $display("FAIL bl_wb got=%b/%0d/%h exp=1/9/00bb0000", wb_we_o, wb_rd_o, wb_data_o);
    end
  endtask

  task automatic test_reset_mid();
    ex_vld_i = 1'b1; ex_rd_i = 5'd6; mem_addr_i = 32'h300; mem_rden_i = 4'hF;
    tick();
    idle_inputs();
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rm_inwait got=%b exp=0", in_ready_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, wb_we_o, error_o, in_ready_o} !==
        {1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rm_reset got=req%b a%h be%h we%b err%b rdy%b exp=all0 rdy1", dbus_req_o,
               dbus_addr_o, dbus_be_o, wb_we_o, error_o, in_ready_o);
    end
    tick();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hBAD0_BAD0;
    tick();
    idle_inputs();
    checks++;
    if (wb_we_o !== 1'b0 || in_ready_o !== 1'b1 || dbus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL rm_stray got=we%b rdy%b req%b exp=we0 rdy1 req0", wb_we_o, in_ready_o,
               dbus_req_o);
    end
  endtask

  task automatic test_both_en();
    ex_vld_i = 1'b1; ex_rd_i = 5'd4; ex_x_rd_vld_i = 1'b1; mem_addr_i = 32'h40;
    mem_rden_i = 4'hF; mem_wren_i = 4'hF;
    tick();
    idle_inputs();
    checks++;
    if ({error_o, dbus_req_o, wb_we_o, in_ready_o} !== 4'b1001) begin
      failures++;
      $display("FAIL both_err got=err%b req%b we%b rdy%b exp=err1 req0 we0 rdy1", error_o,
               dbus_req_o, wb_we_o, in_ready_o);
    end
    tick();
    checks++;
    if (error_o !== 1'b0 || dbus_req_o !== 1'b0) begin
      failures++;
      $display("FAIL both_pulse got=err%b req%b exp=err0 req0", error_o, dbus_req_o);
    end
  endtask

  task automatic test_misalign();
    ex_vld_i = 1'b1; ex_rd_i = 5'd8; mem_addr_i = 32'h102; mem_rden_i = 4'hF;
    tick();
    idle_inputs();
`ifdef MEM_MISALIGN_CHK_EN
    checks++;
    if ({error_o, dbus_req_o, in_ready_o} !== 3'b101) begin
      failures++;
      $display("FAIL mis_chk got=err%b req%b rdy%b exp=err1 req0 rdy1", error_o, dbus_req_o,
               in_ready_o);
    end
    tick();
    checks++;
    if (wb_we_o !== 1'b0 || error_o !== 1'b0) begin
      failures++;
      $display("FAIL mis_after got=we%b err%b exp=we0 err0", wb_we_o, error_o);
    end
`else
    checks++;
    if ({error_o, dbus_req_o, dbus_addr_o} !== {1'b0, 1'b1, 32'h100}) begin
      failures++;
      $display("FAIL mis_nochk got=err%b req%b a%h exp=err0 req1 a100", error_o, dbus_req_o,
               dbus_addr_o);
    end
    dbus_gnt_i = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h0000_0055;
    tick();
    idle_inputs();
    checks++;
    if ({wb_we_o, wb_rd_o, wb_data_o} !== {1'b1, 5'd8, 32'h0000_0055}) begin
      failures++;
      $display("FAIL mis_wb got=%b/%0d/%h exp=1/8/00000055", wb_we_o, wb_rd_o, wb_data_o);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_wait();
    test_store();
    test_load_rd0();
    test_byte_load();
    test_reset_mid();
    test_both_en();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
